// File: rtl/timeout_multi_pkg.sv
// rtl/timeout_multi_pkg.sv - shared state encoding and mode constants for timeout_multi
package timeout_multi_pkg;

    typedef enum logic {
        READY    = 1'b0,
        COUNTING = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timeout_channel.sv
// rtl/timeout_channel.sv - one timer channel (FSM + counter); pause input under TIMEOUT_MULTI_PAUSE_EN
module timeout_channel
    import timeout_multi_pkg::*;
#(
    parameter int CNT_LEN = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               cancel_i,
    input  logic               periodic_i,
    input  logic [CNT_LEN-1:0] timeout_i,
`ifdef TIMEOUT_MULTI_PAUSE_EN
    input  logic               pause_i,
`endif
    output logic               busy_o,
    output logic               expired_o
);

    localparam logic [CNT_LEN-1:0] ONE = {{(CNT_LEN-1){1'b0}}, 1'b1};

    state_e             state_q;
    logic [CNT_LEN-1:0] cnt_q;
    logic [CNT_LEN-1:0] tmo_q;
    logic               mode_q;
    logic               paused;
    logic               term;

`ifdef TIMEOUT_MULTI_PAUSE_EN
    assign paused = pause_i;
`else
    assign paused = 1'b0;
`endif

    // A latched period of 0 terminates on the first count, the same as 1,
    // because cnt_q always starts at 1.
    assign term      = (state_q == COUNTING) && (cnt_q >= tmo_q);
    assign expired_o = term && !paused;
    assign busy_o    = (state_q == COUNTING);

    // Channel FSM: cancel beats retrigger beats pause beats terminal handling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= READY;
            cnt_q   <= ONE;
            tmo_q   <= '0;
            mode_q  <= MODE_ONESHOT;
        end else begin
            case (state_q)
                READY: begin
                    if (enable_i && !cancel_i) begin
                        state_q <= COUNTING;
                        cnt_q   <= ONE;
                        tmo_q   <= timeout_i;
                        mode_q  <= periodic_i;
                    end
                end
                COUNTING: begin
                    if (cancel_i) begin
                        state_q <= READY;
                        cnt_q   <= ONE;
                    end else if (enable_i) begin
                        cnt_q  <= ONE;
                        tmo_q  <= timeout_i;
                        mode_q <= periodic_i;
                    end else if (paused) begin
                        cnt_q <= cnt_q;
                    end else if (term) begin
                        cnt_q <= ONE;
                        if (mode_q != MODE_PERIODIC) begin
                            state_q <= READY;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= READY;
                    cnt_q   <= ONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/timeout_multi.sv
// rtl/timeout_multi.sv - NUM_CH independent timeout channels with OR-reduced irq; pause under TIMEOUT_MULTI_PAUSE_EN
module timeout_multi
    import timeout_multi_pkg::*;
#(
    parameter int CNT_LEN = 8,
    parameter int NUM_CH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH-1:0]         cancel,
    input  logic [NUM_CH-1:0]         periodic,
    input  logic [NUM_CH*CNT_LEN-1:0] timeout,
`ifdef TIMEOUT_MULTI_PAUSE_EN
    input  logic [NUM_CH-1:0]         pause,
`endif
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         expired,
    output logic                      irq
);

    // One fully independent timer per channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timeout_channel #(
            .CNT_LEN (CNT_LEN)
        ) u_ch (
            .clk_i      (clk),
            .rst_ni     (rst),
            .enable_i   (enable[i]),
            .cancel_i   (cancel[i]),
            .periodic_i (periodic[i]),
            .timeout_i  (timeout[i*CNT_LEN +: CNT_LEN]),
`ifdef TIMEOUT_MULTI_PAUSE_EN
            .pause_i    (pause[i]),
`endif
            .busy_o     (busy[i]),
            .expired_o  (expired[i])
        );
    end

    assign done = ~busy;
    assign irq  = |expired;

endmodule

// File: tb/tb_timeout_multi.sv
// tb/tb_timeout_multi.sv - directed self-checking bench for timeout_multi
module tb_timeout_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  enable;
    logic [3:0]  cancel;
    logic [3:0]  periodic;
    logic [31:0] timeout;
    logic [3:0]  pause;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  expired;
    logic        irq;

    int total_cnt;
    int pass_cnt;
    int busy_cycles;
    int exp_cycle;

    timeout_multi #(
        .CNT_LEN (8),
        .NUM_CH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cancel   (cancel),
        .periodic (periodic),
        .timeout  (timeout),
`ifdef TIMEOUT_MULTI_PAUSE_EN
        .pause    (pause),
`endif
        .busy     (busy),
        .done     (done),
        .expired  (expired),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_t(input int ch, input logic [7:0] val);
        timeout[ch*8 +: 8] = val;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst      = 1'b0;
        enable   = '0;
        cancel   = '0;
        periodic = '0;
        timeout  = '0;
        pause    = '0;

        // Reset then idle
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'hf);
        chk("rst_expired", 32'(expired), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // One-shot ch0, T=5, timeout changed mid-count
        set_t(0, 8'd5);
        enable[0] = 1'b1;
        tick();
        enable[0] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("os_busy_c%0d", c), 32'(busy[0]), 32'(c <= 5));
            chk($sformatf("os_exp_c%0d", c), 32'(expired[0]), 32'(c == 5));
            chk($sformatf("os_irq_c%0d", c), 32'(irq), 32'(c == 5));
            if (c == 2) set_t(0, 8'd9);
            tick();
        end

        // Periodic ch1, T=3, cancel during cycle 7
        set_t(1, 8'd3);
        periodic[1] = 1'b1;
        enable[1]   = 1'b1;
        tick();
        enable[1]   = 1'b0;
        periodic[1] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("per_busy_c%0d", c), 32'(busy[1]), 32'(c <= 7));
            chk($sformatf("per_exp_c%0d", c), 32'(expired[1]), 32'(c == 3 || c == 6));
            cancel[1] = (c == 7);
            tick();
        end
        cancel[1] = 1'b0;

        // Retrigger ch2, T=4, second enable in cycle 3
        set_t(2, 8'd4);
        enable[2] = 1'b1;
        tick();
        enable[2] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("rt_busy_c%0d", c), 32'(busy[2]), 32'(c <= 7));
            chk($sformatf("rt_exp_c%0d", c), 32'(expired[2]), 32'(c == 7));
            enable[2] = (c == 3);
            tick();
        end
        enable[2] = 1'b0;

        // Cancel and enable together while counting: cancel wins
        enable[2] = 1'b1;
        tick();
        enable[2] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("ce_busy_c%0d", c), 32'(busy[2]), 32'(c <= 2));
            chk($sformatf("ce_exp_c%0d", c), 32'(expired[2]), 32'h0);
            enable[2] = (c == 2);
            cancel[2] = (c == 2);
            tick();
        end
        enable[2] = 1'b0;
        cancel[2] = 1'b0;

        // Cancel with enable in READY: channel stays idle
        enable[3] = 1'b1;
        cancel[3] = 1'b1;
        set_t(3, 8'd2);
        tick();
        enable[3] = 1'b0;
        cancel[3] = 1'b0;
        chk("ready_ce_busy", 32'(busy[3]), 32'h0);

        // T=0 and T=1 both give one busy cycle with expired
        for (int t = 0; t <= 1; t++) begin
            set_t(0, 8'(t));
            enable[0] = 1'b1;
            tick();
            enable[0] = 1'b0;
            chk($sformatf("t%0d_busy1", t), 32'(busy[0]), 32'h1);
            chk($sformatf("t%0d_exp1", t), 32'(expired[0]), 32'h1);
            tick();
            chk($sformatf("t%0d_busy2", t), 32'(busy[0]), 32'h0);
            chk($sformatf("t%0d_exp2", t), 32'(expired[0]), 32'h0);
        end

        // T=255: no wrap, 255 busy cycles, expiry on the last
        set_t(1, 8'd255);
        enable[1] = 1'b1;
        tick();
        enable[1] = 1'b0;
        busy_cycles = 0;
        exp_cycle   = -1;
        for (int c = 1; c <= 300; c++) begin
            if (busy[1]) busy_cycles++;
            if (expired[1]) exp_cycle = c;
            tick();
        end
        chk("t255_busy_cycles", 32'(busy_cycles), 32'd255);
        chk("t255_exp_cycle", 32'(exp_cycle), 32'd255);

        // All channels at once, T = 2,2,3,4
        set_t(0, 8'd2);
        set_t(1, 8'd2);
        set_t(2, 8'd3);
        set_t(3, 8'd4);
        enable = 4'hf;
        tick();
        enable = 4'h0;
        begin
            logic [3:0] exp_busy [1:5];
            logic [3:0] exp_exp  [1:5];
            exp_busy[1] = 4'hf; exp_exp[1] = 4'h0;
            exp_busy[2] = 4'hf; exp_exp[2] = 4'h3;
            exp_busy[3] = 4'hc; exp_exp[3] = 4'h4;
            exp_busy[4] = 4'h8; exp_exp[4] = 4'h8;
            exp_busy[5] = 4'h0; exp_exp[5] = 4'h0;
            for (int c = 1; c <= 5; c++) begin
                chk($sformatf("all_busy_c%0d", c), 32'(busy), 32'(exp_busy[c]));
                chk($sformatf("all_exp_c%0d", c), 32'(expired), 32'(exp_exp[c]));
                chk($sformatf("all_irq_c%0d", c), 32'(irq), 32'(c >= 2 && c <= 4));
                tick();
            end
        end

        // Reset mid-count on ch3, T=10
        set_t(3, 8'd10);
        enable[3] = 1'b1;
        tick();
        enable[3] = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy_before", 32'(busy[3]), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_busy_async", 32'(busy[3]), 32'h0);
        chk("mid_exp_async", 32'(expired), 32'h0);
        chk("mid_irq_async", 32'(irq), 32'h0);
        tick();
        chk("mid_exp_held", 32'(expired), 32'h0);
        rst = 1'b1;
        tick();
        enable[3] = 1'b1;
        tick();
        enable[3] = 1'b0;
        busy_cycles = 0;
        exp_cycle   = -1;
        for (int c = 1; c <= 14; c++) begin
            if (busy[3]) busy_cycles++;
            if (expired[3]) exp_cycle = c;
            tick();
        end
        chk("fresh_busy_cycles", 32'(busy_cycles), 32'd10);
        chk("fresh_exp_cycle", 32'(exp_cycle), 32'd10);

`ifdef TIMEOUT_MULTI_PAUSE_EN
        // Pause ch0 during cycles 2-4 with T=6: expiry moves to cycle 9
        set_t(0, 8'd6);
        enable[0] = 1'b1;
        tick();
        enable[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            pause[0] = (c >= 2 && c <= 4);
            #1;
            chk($sformatf("pz_busy_c%0d", c), 32'(busy[0]), 32'(c <= 9));
            chk($sformatf("pz_exp_c%0d", c), 32'(expired[0]), 32'(c == 9));
            tick();
        end
        pause[0] = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
